// File: rtl/symbol_unpacker.sv
// symbol_unpacker: takes one 50-bit word of ten 5-bit symbols per input handshake.
// It emits the valid symbols one per cycle, LSB symbol first, on a valid/ready stream.
// It marks the final symbol of a frame and keeps a sticky error for illegal counts.
// Optional build macro: SYMBOL_UNPACKER_PREFETCH_EN adds a second word register,
// so in_ready becomes purely registered.
module symbol_unpacker #(
  parameter int unsigned SYM_W = 5,
  parameter int unsigned SYMS  = 10,
  parameter logic [SYM_W-1:0] FILL = 5'h00
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SYM_W*SYMS-1:0]   in_data,
  input  logic [3:0]              in_count,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SYM_W-1:0]        out_sym,
  output logic                    out_last,
  output logic                    err
);

  localparam int unsigned WORD_W = SYM_W * SYMS;

  logic [WORD_W-1:0] cur;
  logic [3:0]        cnt;
  logic              cur_last;

  logic              in_fire;
  logic              out_fire;
  logic              count_ok;
  logic              cur_free;
  logic              load_cur;
  logic [WORD_W-1:0] load_data;
  logic [3:0]        load_count;
  logic              load_last;

  assign out_valid = (cnt != 4'd0);
  assign out_sym   = cur[SYM_W-1:0];
  assign out_last  = cur_last & (cnt == 4'd1);

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign count_ok = (in_count != 4'd0) && (in_count <= 4'(SYMS));
  // cur holds nothing after this edge: it is already empty, or its last symbol leaves now
  assign cur_free = (cnt == 4'd0) | ((cnt == 4'd1) & out_ready);

`ifdef SYMBOL_UNPACKER_PREFETCH_EN
  logic [WORD_W-1:0] nxt;
  logic [3:0]        nxt_count;
  logic              nxt_last;
  logic              nxt_valid;
  logic              pop_nxt;
  logic              load_direct;
  logic              push_nxt;

  assign in_ready    = ~nxt_valid;
  assign pop_nxt     = cur_free & nxt_valid;
  // a word bypasses nxt only when nothing is queued ahead of it
  assign load_direct = in_fire & count_ok & cur_free & ~nxt_valid;
  assign push_nxt    = in_fire & count_ok & ~load_direct;

  assign load_cur    = pop_nxt | load_direct;
  assign load_data   = pop_nxt ? nxt       : in_data;
  assign load_count  = pop_nxt ? nxt_count : in_count;
  assign load_last   = pop_nxt ? nxt_last  : in_last;

  // Prefetch register: filled by accepted words that cannot go to cur, emptied when cur frees up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nxt       <= '0;
      nxt_count <= '0;
      nxt_last  <= 1'b0;
      nxt_valid <= 1'b0;
    end else if (push_nxt) begin
      nxt       <= in_data;
      nxt_count <= in_count;
      nxt_last  <= in_last;
      nxt_valid <= 1'b1;
    end else if (pop_nxt) begin
      nxt_valid <= 1'b0;
    end
  end
`else
  assign in_ready   = cur_free;
  assign load_cur   = in_fire & count_ok;
  assign load_data  = in_data;
  assign load_count = in_count;
  assign load_last  = in_last;
`endif

  // Holding register: a load takes priority over the per-beat right shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= '0;
      cnt      <= '0;
      cur_last <= 1'b0;
    end else if (load_cur) begin
      cur      <= load_data;
      cnt      <= load_count;
      cur_last <= load_last;
    end else if (out_fire) begin
      cur <= {FILL, cur[WORD_W-1:SYM_W]};
      cnt <= cnt - 4'd1;
    end
  end

  // Sticky error: an illegal count completes its handshake but only sets err
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (in_fire & ~count_ok) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_symbol_unpacker.sv
// Directed testbench for symbol_unpacker.
// Inputs are driven at the falling edge and outputs are checked there.
module tb_symbol_unpacker;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [49:0] in_data;
  logic [3:0]  in_count;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_sym;
  logic        out_last;
  logic        err;

  int checks = 0;
  int errors = 0;

  symbol_unpacker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_count  (in_count),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sym   (out_sym),
    .out_last  (out_last),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [49:0] obs, input logic [49:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // symbol k = first + k for all ten symbol slots
  function automatic logic [49:0] pack_seq(input int first);
    logic [49:0] w;
    w = '0;
    for (int k = 0; k < 10; k++) w[5*k +: 5] = 5'(first + k);
    return w;
  endfunction

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_count  = 4'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 50'(out_valid), 50'd0);
    chk("rst_out_sym",   50'(out_sym),   50'd0);
    chk("rst_out_last",  50'(out_last),  50'd0);
    chk("rst_err",       50'(err),       50'd0);
    chk("rst_in_ready",  50'(in_ready),  50'd1);
    @(negedge clk);

`ifndef SYMBOL_UNPACKER_PREFETCH_EN
    // single 10-symbol word, symbols 01..0A, frame end
    in_valid = 1'b1; in_data = pack_seq(1); in_count = 4'd10; in_last = 1'b1;
    #1 chk("w1_in_ready", 50'(in_ready), 50'd1);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("w1_valid_%0d", k), 50'(out_valid), 50'd1);
      chk($sformatf("w1_sym_%0d", k),   50'(out_sym),   50'(k + 1));
      chk($sformatf("w1_last_%0d", k),  50'(out_last),  50'(k == 9));
      tick();
    end
    chk("w1_drained", 50'(out_valid), 50'd0);

    // back-to-back: count 10 (11..1A, not last) then count 3 (01..03, last)
    in_valid = 1'b1; in_data = pack_seq(17); in_count = 4'd10; in_last = 1'b0;
    tick();
    in_data = pack_seq(1); in_count = 4'd3; in_last = 1'b1;
    for (int k = 0; k < 13; k++) begin
      if (k == 10) in_valid = 1'b0;
      #1;
      chk($sformatf("b2b_valid_%0d", k), 50'(out_valid), 50'd1);
      chk($sformatf("b2b_sym_%0d", k),   50'(out_sym),   (k < 10) ? 50'(17 + k) : 50'(k - 9));
      chk($sformatf("b2b_last_%0d", k),  50'(out_last),  50'(k == 12));
      if (k == 8) chk("b2b_in_ready_busy", 50'(in_ready), 50'd0);
      if (k == 9) chk("b2b_in_ready_tenth", 50'(in_ready), 50'd1);
      tick();
    end
    chk("b2b_drained", 50'(out_valid), 50'd0);

    // output stall on a count-4 word
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = pack_seq(5); in_count = 4'd4; in_last = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("stall_valid_%0d", k), 50'(out_valid), 50'd1);
      chk($sformatf("stall_sym_%0d", k),   50'(out_sym),   50'h5);
      chk($sformatf("stall_ready_%0d", k), 50'(in_ready),  50'd0);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stall_rel_sym_%0d", k), 50'(out_sym), 50'(5 + k));
      tick();
    end
    chk("stall_drained", 50'(out_valid), 50'd0);

    // illegal counts 0 and 11 presented while a count-6 word drains
    in_valid = 1'b1; in_data = pack_seq(11); in_count = 4'd6; in_last = 1'b1;
    tick();
    in_data = pack_seq(20); in_count = 4'd0; in_last = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("ill_sym_%0d", k), 50'(out_sym), 50'(11 + k));
      chk($sformatf("ill_err_%0d", k), 50'(err),     50'd0);
      if (k == 5) begin
        chk("ill_last", 50'(out_last), 50'd1);
        chk("ill_hs0",  50'(in_ready), 50'd1);
      end
      tick();
    end
    in_count = 4'd11;
    #1;
    chk("ill_err_after0", 50'(err),       50'd1);
    chk("ill_noload0",    50'(out_valid), 50'd0);
    chk("ill_hs11",       50'(in_ready),  50'd1);
    tick();
    in_valid = 1'b0;
    chk("ill_err_after11", 50'(err),       50'd1);
    chk("ill_noload11",    50'(out_valid), 50'd0);

    // asynchronous reset after 3 of 10 symbols
    in_valid = 1'b1; in_data = pack_seq(1); in_count = 4'd10; in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("rmid_sym_before", 50'(out_sym), 50'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("rmid_valid", 50'(out_valid), 50'd0);
    chk("rmid_err",   50'(err),       50'd0);
    chk("rmid_sym",   50'(out_sym),   50'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rmid_in_ready", 50'(in_ready),  50'd1);
    chk("rmid_valid_rel", 50'(out_valid), 50'd0);
    tick();
    chk("rmid_valid_later", 50'(out_valid), 50'd0);
`else
    // prefetch: two words accepted under backpressure, in_ready independent of out_ready
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = pack_seq(1); in_count = 4'd2; in_last = 1'b0;
    #1 chk("pf_ready0", 50'(in_ready), 50'd1);
    tick();
    in_data = pack_seq(3); in_count = 4'd3; in_last = 1'b1;
    #1 chk("pf_ready1", 50'(in_ready), 50'd1);
    tick();
    in_valid = 1'b0;
    #1 chk("pf_full", 50'(in_ready), 50'd0);
    out_ready = 1'b1;
    #1 chk("pf_full_or1", 50'(in_ready), 50'd0);
    out_ready = 1'b0;
    #1 chk("pf_full_or0", 50'(in_ready), 50'd0);
    chk("pf_hold_sym", 50'(out_sym), 50'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("pf_valid_%0d", k), 50'(out_valid), 50'd1);
      chk($sformatf("pf_sym_%0d", k),   50'(out_sym),   50'(k + 1));
      chk($sformatf("pf_last_%0d", k),  50'(out_last),  50'(k == 4));
      tick();
    end
    chk("pf_drained", 50'(out_valid), 50'd0);
    chk("pf_ready_end", 50'(in_ready), 50'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/symbol_unpacker.md
# symbol_unpacker

Sequential word-to-symbol unpacker sitting directly downstream of the 50-bit, 5-bit-symbol right shifter. It accepts one 50-bit word (ten 5-bit symbols, symbol 0 in bits [4:0]) per input handshake together with a valid-symbol count. It emits the symbols one per cycle, LSB symbol first, over a valid/ready stream, shifting its holding register right by one symbol per output beat. It also marks the final symbol of a frame and flags malformed counts.

## Interface
- SYM_W, 5, symbol width in bits (fixed by the shifter datapath)
- SYMS, 10, symbols per input word; word width = SYM_W*SYMS = 50
- FILL, 5'h00, symbol value shifted into the top of the holding register on each output beat
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  input word present
- in_ready  output  1  unpacker can accept a word this cycle
- in_data  input  50  packed symbols, symbol k at [5k+4:5k]
- in_count  input  4  number of valid symbols in in_data, legal 1..10, always taken from symbol 0 upward
- in_last  input  1  word ends a frame
- out_valid  output  1  out_sym holds a valid symbol
- out_ready  input  1  consumer takes out_sym this cycle
- out_sym  output  5  current symbol
- out_last  output  1  out_sym is the final symbol of a frame
- err  output  1  sticky: an illegal in_count was received

## Operation
- State: cur[49:0], cnt[3:0] (symbols remaining in cur, 0..10), cur_last, err.
- Reset values: cur=0, cnt=0, cur_last=0, err=0. Outputs after reset: out_valid=0, out_sym=0, out_last=0, err=0, in_ready=1.
- out_valid = (cnt != 0). out_sym = cur[4:0]. out_last = cur_last & (cnt == 1).
- Output beat (out_valid & out_ready): cur <= {FILL, cur[49:5]} and cnt <= cnt-1.
- Input beat (in_valid & in_ready) with legal in_count:
  - cur <= in_data, cnt <= in_count, cur_last <= in_last.
  - The load overrides the shift in the same cycle.
- Input beat with in_count = 0 or > 10:
  - Handshake completes and the word is discarded.
  - err <= 1. cur, cnt and cur_last are untouched; an in-progress word continues draining.
- err clears only on reset.
- out_valid never depends on in_valid; the output side is fully registered.

## Timing
- Latency: a word accepted in cycle t presents symbol 0 in cycle t+1.
- in_ready (base build) = (cnt == 0) | (cnt == 1 & out_ready). This is a combinational path from out_ready to in_ready.
- Gapless throughput: with continuous in_valid and out_ready, the unpacker delivers one symbol every cycle across word boundaries. Each word occupies exactly in_count output cycles.
- Simultaneous final output beat and input beat: the last symbol of the old word is delivered and the new word is loaded in the same edge.
- Output stall (out_ready=0): cur, cnt and out_* are held stable; out_valid must not drop.
- Reset mid-word: the remaining symbols are lost; the first cycle after release presents reset values.

## Configuration
- SYMBOL_UNPACKER_PREFETCH_EN defined:
  - Adds a second word register nxt with nxt_valid, nxt_count and nxt_last. in_ready = ~nxt_valid, which is purely registered with no out_ready path.
  - Destination of an accepted word:
    - If cur is empty, or drains this cycle, and nxt is empty, the word loads into cur directly.
    - Otherwise it loads into nxt.
  - When cur empties, or drains this cycle, and nxt_valid=1, cur loads from nxt and nxt_valid <= 0.
  - The illegal-count rule is unchanged; illegal words never occupy nxt.
  - Reset: nxt=0, nxt_valid=0.
- SYMBOL_UNPACKER_PREFETCH_EN undefined: single-register behaviour as described above.

## Test plan
- Reset, then send in_data with symbols 0..9 = 5'h01..5'h0A, in_count=10, in_last=1, out_ready=1:
  - out_sym sequence 01..0A on cycles t+1..t+10.
  - out_last=1 only on 0A.
  - out_valid=0 from t+11.
- Send two back-to-back words (count 10, then count 3) with out_ready=1: thirteen consecutive out_valid cycles with no gap, and in_ready=1 on the cycle the tenth symbol is taken.
- Load a count-4 word, hold out_ready=0 for 5 cycles: out_sym stays at symbol 0, cnt stays 4, in_ready=0. After release, 4 symbols follow.
- Send in_count=0, then in_count=11, mid-drain of a count-6 word: both handshakes complete, err=1 from the cycle after the first, and the count-6 word still outputs all 6 symbols.
- Assert rst_n=0 asynchronously mid-word (3 of 10 symbols sent): out_valid=0 immediately, err=0, in_ready=1 after release.
- With SYMBOL_UNPACKER_PREFETCH_EN, out_ready=0, send two words: both are accepted and in_ready=0 afterwards. in_ready must not toggle when out_ready toggles.
